alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Byte-stream front end for the ALU. Collects three serially received bytes (operand A, operand B, opcode) from the UART receiver and drives them onto the ALU's `Data_A`, `Data_B` and `Op` inputs. It then samples the ALU's `LEDS` result and hands it to the UART transmitter with a start/done handshake. It sits between the UART RX/TX blocks and the ALU in the top level, replacing switch/button operand entry.

## Interface
- `N_BITS`, default 6: ALU data width. Legal range is 1..8; out-of-range values are a synthesis error.
- `clock` in 1: single system clock. All logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from the UART receiver. Valid only while `rx_done` = 1.
- `rx_done` in 1: one-cycle strobe, "byte received".
- `alu_result` in N_BITS: ALU `LEDS` output.
- `tx_done` in 1: one-cycle strobe, "transmitter finished the byte".
- `data_a` out N_BITS: drives ALU `Data_A`.
- `data_b` out N_BITS: drives ALU `Data_B`.
- `op` out 6: drives ALU `Op`.
- `tx_data` out 8: byte to transmit.
- `tx_start` out 1: one-cycle strobe, "start transmission".
- `busy` out 1: high in EXEC, SEND and WAIT_TX.
- `op_error` out 1: one-cycle strobe, "invalid opcode rejected".

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. State encoding is free.
- WAIT_A, on `rx_done`: `data_a <= rx_data[N_BITS-1:0]`, go to WAIT_B.
- WAIT_B, on `rx_done`: `data_b <= rx_data[N_BITS-1:0]`, go to WAIT_OP.
- WAIT_OP, on `rx_done`:
  - Valid opcode: `op <= rx_data[5:0]`, go to EXEC.
  - The valid set, checked on `rx_data[5:0]` with `rx_data[7:6]` ignored, is:
    - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR
    - 0x26 XOR, 0x03 SRA, 0x02 SRL, 0x27 NOR
  - Any other value: `op` is unchanged, `op_error` pulses, go to WAIT_A. `data_a` and `data_b` keep their captured values.
- EXEC: lasts one cycle, which lets the combinational ALU settle. Then `tx_data <= {zeros, alu_result}` (zero-extended to 8 bits), `tx_start <= 1`, go to SEND.
- SEND: lasts one cycle. `tx_start <= 0`, go to WAIT_TX.
- WAIT_TX, on `tx_done`: go to WAIT_A.
- Operand stability: `data_a`, `data_b`, `op` and `tx_data` hold their values until the next capture. The ALU output therefore stays stable between transactions.
- `rx_done` in EXEC, SEND or WAIT_TX: the byte is dropped and there is no state change.
- `tx_done` outside WAIT_TX: ignored.
- `rx_done` and `tx_done` together in WAIT_TX: `tx_done` is taken and the byte is dropped.
- `busy` is a registered output and changes on the same edge as the state.

## Timing
- Reset (`reset_n` = 0, asynchronous): state WAIT_A, and every output is 0:
  - `data_a`, `data_b`, `op`, `tx_data` = 0
  - `tx_start`, `busy`, `op_error` = 0
- Release is synchronous to the next `clock` edge. Input metastability on release is the top level's concern.
- Reset mid-transaction aborts the transaction immediately. No `tx_start` is issued afterwards.
- Numbering: edge k is the rising edge at which `rx_done` is sampled high with a valid opcode.
  - After edge k: `op` is valid, state EXEC, `busy` = 1.
  - After edge k+1: `tx_data` is valid, `tx_start` = 1.
  - After edge k+2: `tx_start` = 0, state WAIT_TX.
- `tx_start` width is exactly one cycle. Opcode-to-`tx_start` latency is 2 cycles.
- `op_error` is high for the single cycle after the edge that sampled the invalid opcode.
- Minimum gap between accepted bytes is one cycle; back-to-back `rx_done` is legal in the WAIT_* states.
- After the `tx_done` edge, state is WAIT_A and `busy` = 0. A new A byte is accepted on the following edge.

## Test plan
- ADD: bytes 0x0F, 0x14, 0x20 -> `data_a` = 0x0F, `data_b` = 0x14, `op` = 0x20.
  - Two edges after the opcode, `tx_data` = 0x23 and `tx_start` pulses once.
  - `tx_done` -> `busy` = 0.
- SUB then XOR, back to back with `tx_done` between them:
  - 0x14, 0x0F, 0x22 -> `tx_data` = 0x05.
  - 0x0F, 0x14, 0x26 -> `tx_data` = 0x1B.
- Truncation: bytes 0xFF, 0xC3, 0xE4 (AND), with N_BITS = 6:
  - Captures: `data_a` = 0x3F, `data_b` = 0x03, `op` = 0x24.
  - Result: `tx_data` = 0x03.
- Invalid opcode: 0x0F, 0x14, 0x01 -> `op_error` pulses for one cycle, `op` stays at its prior value, no `tx_start`.
  - A next byte 0x05 lands in `data_a`.
- Ignored bytes: `rx_done` with 0xAA during EXEC and again during WAIT_TX -> no register or state change.
  - `rx_done` and `tx_done` together in WAIT_TX -> state WAIT_A, `data_a` unchanged.
- Reset in WAIT_B: after byte 0x0F, assert `reset_n` = 0 asynchronously -> all outputs 0 immediately.
  - After release, bytes 0x01, 0x02, 0x20 -> `tx_data` = 0x03.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Byte-stream front end for the ALU: gathers operand A, operand B and opcode from
// the UART receiver, holds them on the ALU inputs and ships the result to the UART transmitter.
module alu_operand_sequencer #(
    parameter int N_BITS = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic [N_BITS-1:0] alu_result,
    input  logic              tx_done,
    output logic [N_BITS-1:0] data_a,
    output logic [N_BITS-1:0] data_b,
    output logic [5:0]        op,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              op_error
);

    if (N_BITS < 1 || N_BITS > 8) begin : g_bad_width
        $error("alu_operand_sequencer: N_BITS must be in 1..8");
    end

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] data_a_q, data_a_d;
    logic [N_BITS-1:0] data_b_q, data_b_d;
    logic [5:0]        op_q, op_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              op_error_q, op_error_d;

    function automatic logic opcode_is_valid(input logic [5:0] code);
        case (code)
            6'h20, 6'h22, 6'h24, 6'h25,
            6'h26, 6'h03, 6'h02, 6'h27: opcode_is_valid = 1'b1;
            default:                    opcode_is_valid = 1'b0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned; an unassigned path in always_comb infers a latch.
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        op_error_d = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (rx_done) begin
                    data_a_d = rx_data[N_BITS-1:0];
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done) begin
                    data_b_d = rx_data[N_BITS-1:0];
                    state_d  = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (rx_done) begin
                    if (opcode_is_valid(rx_data[5:0])) begin
                        op_d    = rx_data[5:0];
                        state_d = EXEC;
                    end else begin
                        op_error_d = 1'b1;
                        state_d    = WAIT_A;
                    end
                end
            end
            EXEC: begin
                // The ALU has had a full cycle on the new operands; sample it now.
                tx_data_d                = '0;
                tx_data_d[N_BITS-1:0]    = alu_result;
                tx_start_d               = 1'b1;
                state_d                  = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase

        busy_d = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            op_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            op_error_q <= op_error_d;
        end
    end

    assign data_a   = data_a_q;
    assign data_b   = data_b_q;
    assign op       = op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign op_error = op_error_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: a vector table of full transactions
// plus hand-written sequences for invalid opcodes, dropped bytes and resets.
module tb_alu_operand_sequencer;

    localparam int N_BITS = 6;

    logic              clock;
    logic              reset_n;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic [N_BITS-1:0] alu_result;
    logic              tx_done;
    logic [N_BITS-1:0] data_a;
    logic [N_BITS-1:0] data_b;
    logic [5:0]        op;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              busy;
    logic              op_error;

    int errors = 0;
    int checks = 0;
    int tx_starts = 0;

    alu_operand_sequencer #(.N_BITS(N_BITS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .alu_result (alu_result),
        .tx_done    (tx_done),
        .data_a     (data_a),
        .data_b     (data_b),
        .op         (op),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .op_error   (op_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the combinational ALU driven by the sequencer's outputs.
    always_comb begin
        case (op)
            6'h20:   alu_result = data_a + data_b;
            6'h22:   alu_result = data_a - data_b;
            6'h24:   alu_result = data_a & data_b;
            6'h25:   alu_result = data_a | data_b;
            6'h26:   alu_result = data_a ^ data_b;
            6'h27:   alu_result = ~(data_a | data_b);
            6'h02:   alu_result = data_a >> data_b;
            6'h03:   alu_result = N_BITS'($signed(data_a) >>> data_b);
            default: alu_result = '0;
        endcase
    end

    always @(negedge clock) begin
        if (tx_start) tx_starts++;
    end

    typedef struct {
        logic [7:0] a, b, opc;
        logic [7:0] exp_a, exp_b, exp_op, exp_tx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    // Called just after the edge that accepted a valid opcode.
    task automatic expect_tx(input string tag, input logic [7:0] exp_tx);
        int starts_before;
        starts_before = tx_starts;
        check({tag, " busy@exec"}, 32'(busy), 32'd1);
        check({tag, " tx_start@exec"}, 32'(tx_start), 32'd0);
        tick();
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp_tx));
        check({tag, " tx_start@send"}, 32'(tx_start), 32'd1);
        tick();
        check({tag, " tx_start@wait_tx"}, 32'(tx_start), 32'd0);
        check({tag, " busy@wait_tx"}, 32'(busy), 32'd1);
        tick();
        check({tag, " tx_start count"}, 32'(tx_starts - starts_before), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, " busy after tx_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_a"}, 32'(data_a), 32'd0);
        check({tag, " data_b"}, 32'(data_b), 32'd0);
        check({tag, " op"}, 32'(op), 32'd0);
        check({tag, " tx_data"}, 32'(tx_data), 32'd0);
        check({tag, " tx_start"}, 32'(tx_start), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " op_error"}, 32'(op_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts_before;

        vecs[0] = '{8'h0F, 8'h14, 8'h20, 8'h0F, 8'h14, 8'h20, 8'h23}; // ADD
        vecs[1] = '{8'h14, 8'h0F, 8'h22, 8'h14, 8'h0F, 8'h22, 8'h05}; // SUB
        vecs[2] = '{8'h0F, 8'h14, 8'h26, 8'h0F, 8'h14, 8'h26, 8'h1B}; // XOR
        vecs[3] = '{8'hFF, 8'hC3, 8'hE4, 8'h3F, 8'h03, 8'h24, 8'h03}; // AND, truncated
        vecs[4] = '{8'h05, 8'h0A, 8'h25, 8'h05, 8'h0A, 8'h25, 8'h0F}; // OR
        vecs[5] = '{8'h0F, 8'h14, 8'h27, 8'h0F, 8'h14, 8'h27, 8'h20}; // NOR
        vecs[6] = '{8'h30, 8'h02, 8'h02, 8'h30, 8'h02, 8'h02, 8'h0C}; // SRL
        vecs[7] = '{8'h70, 8'h42, 8'hC3, 8'h30, 8'h02, 8'h03, 8'h3C}; // SRA, truncated

        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;

        // Table-driven full transactions.
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send_byte(vecs[i].a);
            check({tag, " data_a"}, 32'(data_a), 32'(vecs[i].exp_a));
            check({tag, " busy@wait_b"}, 32'(busy), 32'd0);
            send_byte(vecs[i].b);
            check({tag, " data_b"}, 32'(data_b), 32'(vecs[i].exp_b));
            send_byte(vecs[i].opc);
            check({tag, " op"}, 32'(op), 32'(vecs[i].exp_op));
            check({tag, " op_error"}, 32'(op_error), 32'd0);
            expect_tx(tag, vecs[i].exp_tx);
        end

        // Invalid opcode: op keeps 0x03 from the last vector, no transmission.
        starts_before = tx_starts;
        send_byte(8'h0F);
        send_byte(8'h14);
        send_byte(8'h01);
        check("inv op_error pulse", 32'(op_error), 32'd1);
        check("inv op held", 32'(op), 32'h03);
        check("inv busy", 32'(busy), 32'd0);
        tick();
        check("inv op_error width", 32'(op_error), 32'd0);
        tick();
        check("inv no tx_start", 32'(tx_starts - starts_before), 32'd0);
        send_byte(8'h05);
        check("inv next data_a", 32'(data_a), 32'h05);
        check("inv data_b kept", 32'(data_b), 32'h14);
        send_byte(8'h14);
        send_byte(8'h20);
        check("inv recovery op", 32'(op), 32'h20);
        expect_tx("inv recovery", 8'h19);

        // Bytes arriving while busy are dropped.
        send_byte(8'h0F);
        send_byte(8'h14);
        rx_data = 8'h20;
        rx_done = 1'b1;
        tick();
        rx_data = 8'hAA;
        tick();
        rx_done = 1'b0;
        check("drop exec tx_start", 32'(tx_start), 32'd1);
        check("drop exec tx_data", 32'(tx_data), 32'h23);
        check("drop exec data_a", 32'(data_a), 32'h0F);
        check("drop exec data_b", 32'(data_b), 32'h14);
        check("drop exec op", 32'(op), 32'h20);
        tick();
        check("drop send tx_start", 32'(tx_start), 32'd0);
        send_byte(8'hAA);
        check("drop wait_tx busy", 32'(busy), 32'd1);
        check("drop wait_tx data_a", 32'(data_a), 32'h0F);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("both busy", 32'(busy), 32'd0);
        check("both data_a", 32'(data_a), 32'h0F);

        // Asynchronous reset in WAIT_B.
        send_byte(8'h0F);
        check("rst_b data_a", 32'(data_a), 32'h0F);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_b async");
        tick();
        reset_n = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        check("rst_b recovery op", 32'(op), 32'h20);
        expect_tx("rst_b recovery", 8'h03);

        // Reset in EXEC must suppress the pending tx_start.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        starts_before = tx_starts;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_exec busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("rst_exec no tx_start", 32'(tx_starts - starts_before), 32'd0);
        check("rst_exec idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
